// File: rtl/ecc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ecc_pkg                                                      |
// | Description : Shared types and width helpers for the ECC scrub controller.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package ecc_pkg;

    // Scrubber sequencing states, explicitly encoded on 3 bits
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        READ  = 3'd2,
        CHECK = 3'd3,
        WRITE = 3'd4,
        NEXT  = 3'd5
    } scrub_state_e;

    // Number of Hamming parity bits for a code word of code_w bits
    function automatic int par_w(input int code_w);
        return $clog2(code_w);
    endfunction

    // Payload bits left after Hamming parity and the overall parity bit
    function automatic int data_w(input int code_w);
        return code_w - 1 - par_w(code_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/scrub_sat_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : scrub_sat_cnt                                                |
// | Description : Saturating up-counter; holds at all-ones, clears on reset.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module scrub_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count events, sticking at the maximum value instead of wrapping
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/ecc_scrub_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ecc_scrub_ctrl                                               |
// | Description : Background SECDED scrubber for one memory bank. Reads every  |
// |               word, checks it through the external decoder/encoder pair,   |
// |               writes back corrected words and counts errors. Yields the    |
// |               memory port whenever the user path is busy.                  |
// |               Optional macro ECC_SCRUB_LOG_EN adds o_dbit_flag and         |
// |               o_dbit_addr (double-bit error logging).                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ecc_scrub_ctrl
    import ecc_pkg::*;
#(
    parameter  int CODE_W   = 7,
    parameter  int PAR_W    = par_w(CODE_W),
    parameter  int ADDR_W   = 4,
    parameter  int INTERVAL = 4,
    parameter  int CNT_W    = 8,
    localparam int DATA_W   = CODE_W - 1 - PAR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_scrub_en,
    input  logic              i_user_busy,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [CODE_W-1:0] o_mem_wdata,
    input  logic [CODE_W-1:0] i_mem_rdata,
    output logic [CODE_W-1:0] o_dec_code,
    input  logic [DATA_W-1:0] i_dec_data,
    input  logic              i_dec_dbit_err,
    output logic [DATA_W-1:0] o_enc_data,
    input  logic [CODE_W-1:0] i_enc_code,
    output logic              o_busy,
    output logic              o_pass_done,
    output logic [CNT_W-1:0]  o_sbit_cnt,
`ifdef ECC_SCRUB_LOG_EN
    output logic              o_dbit_flag,
    output logic [ADDR_W-1:0] o_dbit_addr,
`else
    // double-bit logging ports are absent in this build
`endif
    output logic [CNT_W-1:0]  o_dbit_cnt
);

    localparam logic [ADDR_W-1:0]   c_LAST_ADDR = {ADDR_W{1'b1}};
    localparam int                  c_IVAL_W    = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [c_IVAL_W-1:0] c_IVAL_LAST = c_IVAL_W'((INTERVAL > 0) ? INTERVAL - 1 : 0);
    // With no idle gap the next word is read straight away
    localparam scrub_state_e        c_RESUME    = (INTERVAL == 0) ? READ : WAIT;

    scrub_state_e        r_state;
    scrub_state_e        w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_IVAL_W-1:0] r_ival;
    logic [CODE_W-1:0]   r_wdata;
    logic                w_sbit_inc;
    logic                w_dbit_inc;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, memory strobes and error-count events
    always_comb begin
        w_next      = r_state;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_pass_done = 1'b0;
        w_sbit_inc  = 1'b0;
        w_dbit_inc  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_scrub_en) begin
                    w_next = c_RESUME;
                end
            end
            WAIT: begin
                if (r_ival == c_IVAL_LAST) begin
                    w_next = READ;
                end
            end
            READ: begin
                o_mem_req = !i_user_busy;
                if (!i_user_busy) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                // A double-bit word is never also counted as corrected
                if (i_dec_dbit_err) begin
                    w_dbit_inc = 1'b1;
                    w_next     = NEXT;
                end else if (i_mem_rdata != i_enc_code) begin
                    w_sbit_inc = 1'b1;
                    w_next     = WRITE;
                end else begin
                    w_next = NEXT;
                end
            end
            WRITE: begin
                o_mem_req = !i_user_busy;
                o_mem_we  = 1'b1;
                if (!i_user_busy) begin
                    w_next = NEXT;
                end
            end
            NEXT: begin
                o_pass_done = (r_addr == c_LAST_ADDR);
                w_next      = i_scrub_en ? c_RESUME : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Address walk, idle-gap timer and write-back data capture
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr  <= '0;
            r_ival  <= '0;
            r_wdata <= '0;
        end else begin
            r_ival <= (r_state == WAIT) ? r_ival + 1'b1 : '0;
            if (w_sbit_inc) begin
                r_wdata <= i_enc_code;
            end
            if (r_state == NEXT) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    scrub_sat_cnt #(.CNT_W(CNT_W)) u_sbit_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (w_sbit_inc),
        .o_cnt (o_sbit_cnt)
    );

    scrub_sat_cnt #(.CNT_W(CNT_W)) u_dbit_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (w_dbit_inc),
        .o_cnt (o_dbit_cnt)
    );

`ifdef ECC_SCRUB_LOG_EN
    logic              r_dbit_flag;
    logic [ADDR_W-1:0] r_dbit_addr;

    // Sticky double-bit flag plus the address of the latest such word
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dbit_flag <= 1'b0;
            r_dbit_addr <= '0;
        end else if (w_dbit_inc) begin
            r_dbit_flag <= 1'b1;
            r_dbit_addr <= r_addr;
        end
    end

    assign o_dbit_flag = r_dbit_flag;
    assign o_dbit_addr = r_dbit_addr;
`else
    // no double-bit logging state in this build
`endif

    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_dec_code  = i_mem_rdata;
    assign o_enc_data  = i_dec_data;
    assign o_busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ecc_scrub_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ecc_scrub_ctrl                                            |
// | Description : Self-checking bench for ecc_scrub_ctrl: bank, SECDED codec   |
// |               and a per-pass reference model of the scrub outcome.         |
// |               Honours ECC_SCRUB_LOG_EN when defined.                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ecc_scrub_ctrl;

    localparam int CODE_W   = 7;
    localparam int DATA_W   = 3;
    localparam int ADDR_W   = 4;
    localparam int DEPTH    = 16;
    localparam int INTERVAL = 4;
    localparam int CNT_W    = 2;
    localparam int CNT_MAX  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst  = 1'b1;
    logic              en   = 1'b0;
    logic              busy = 1'b0;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [CODE_W-1:0] mem_wdata;
    logic [CODE_W-1:0] mem_rdata = '0;
    logic [CODE_W-1:0] dec_code;
    logic [DATA_W-1:0] dec_data;
    logic              dec_dbit;
    logic [DATA_W-1:0] enc_data;
    logic [CODE_W-1:0] enc_code;
    logic              dut_busy, pass_done;
    logic [CNT_W-1:0]  sbit_cnt, dbit_cnt;
`ifdef ECC_SCRUB_LOG_EN
    logic              dbit_flag;
    logic [ADDR_W-1:0] dbit_addr;
`endif

    ecc_scrub_ctrl #(
        .CODE_W   (CODE_W),
        .ADDR_W   (ADDR_W),
        .INTERVAL (INTERVAL),
        .CNT_W    (CNT_W)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_scrub_en     (en),
        .i_user_busy    (busy),
        .o_mem_req      (mem_req),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .i_mem_rdata    (mem_rdata),
        .o_dec_code     (dec_code),
        .i_dec_data     (dec_data),
        .i_dec_dbit_err (dec_dbit),
        .o_enc_data     (enc_data),
        .i_enc_code     (enc_code),
        .o_busy         (dut_busy),
        .o_pass_done    (pass_done),
        .o_sbit_cnt     (sbit_cnt),
`ifdef ECC_SCRUB_LOG_EN
        .o_dbit_flag    (dbit_flag),
        .o_dbit_addr    (dbit_addr),
`endif
        .o_dbit_cnt     (dbit_cnt)
    );

    // Hamming(6,3) positions 1..6 at bits 0..5, overall parity at bit 6
    function automatic logic [6:0] enc(input logic [2:0] d);
        logic [6:0] c;
        c    = '0;
        c[2] = d[0];
        c[4] = d[1];
        c[5] = d[2];
        c[0] = c[2] ^ c[4];
        c[1] = c[2] ^ c[5];
        c[3] = c[4] ^ c[5];
        c[6] = ^c[5:0];
        return c;
    endfunction

    // Returns {double_error, corrected_data}
    function automatic logic [3:0] dec(input logic [6:0] c);
        logic [2:0] s;
        logic [6:0] cc;
        logic       dbl;
        s   = '0;
        cc  = c;
        dbl = 1'b0;
        for (int p = 1; p <= 6; p++) begin
            if (c[p-1]) s = s ^ 3'(p);
        end
        if (^c) begin
            if (s == 3'd7) dbl = 1'b1;
            else if (s != 3'd0) cc[s-1] = ~cc[s-1];
        end else if (s != 3'd0) begin
            dbl = 1'b1;
        end
        return {dbl, cc[5], cc[4], cc[2]};
    endfunction

    logic [3:0] dec_res;
    assign dec_res  = dec(dec_code);
    assign dec_data = dec_res[2:0];
    assign dec_dbit = dec_res[3];
    assign enc_code = enc(enc_data);

    // Memory bank: read data one cycle after a read strobe, garbage otherwise
    logic [CODE_W-1:0] mem     [DEPTH];
    logic [CODE_W-1:0] pre_mem [DEPTH];
    logic [CODE_W-1:0] orig    [DEPTH];
    logic              mem_load = 1'b0;
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= pre_mem[i];
        end else if (mem_req && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_req && !mem_we) mem_rdata <= mem[mem_addr];
        else                    mem_rdata <= 7'($urandom);
    end

    // Access monitor: log of {we, addr, wdata}, cycle stamps, pass pulses
    int          cyc = 0;
    logic        clr = 1'b0;
    logic [11:0] log_q[$];
    int          stamp_q[$];
    int          pd_cnt = 0;
    int          busy_viol = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            log_q.delete();
            stamp_q.delete();
            pd_cnt    <= 0;
            busy_viol <= 0;
        end else if (!rst) begin
            if (mem_req) begin
                log_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 7'd0});
                stamp_q.push_back(cyc);
            end
            if (pass_done)      pd_cnt    <= pd_cnt + 1;
            if (mem_req && busy) busy_viol <= busy_viol + 1;
        end
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference outcome of one full pass over pre_mem, from a fresh reset
    logic [11:0]       exp_q[$];
    logic [CODE_W-1:0] exp_mem [DEPTH];
    int                exp_s, exp_d, exp_daddr;
    logic              exp_flag;

    task automatic model_pass();
        logic [3:0] r;
        exp_q.delete();
        exp_s = 0; exp_d = 0; exp_daddr = 0; exp_flag = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            exp_mem[a] = pre_mem[a];
            r = dec(pre_mem[a]);
            exp_q.push_back({1'b0, 4'(a), 7'd0});
            if (r[3]) begin
                if (exp_d < CNT_MAX) exp_d++;
                exp_flag  = 1'b1;
                exp_daddr = a;
            end else if (enc(r[2:0]) != pre_mem[a]) begin
                if (exp_s < CNT_MAX) exp_s++;
                exp_mem[a] = enc(r[2:0]);
                exp_q.push_back({1'b1, 4'(a), enc(r[2:0])});
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; busy = 1'b0; clr = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; clr = 1'b0;
    endtask

    task automatic load_mem();
        mem_load = 1'b1;
        @(negedge clk);
        mem_load = 1'b0;
    endtask

    task automatic fill_clean();
        for (int a = 0; a < DEPTH; a++) begin
            orig[a]    = enc(3'($urandom));
            pre_mem[a] = orig[a];
        end
    endtask

    task automatic flip(input int a, input int n);
        int b1, b2;
        b1 = $urandom_range(0, 6);
        pre_mem[a][b1] = ~pre_mem[a][b1];
        if (n == 2) begin
            b2 = (b1 + 1 + $urandom_range(0, 5)) % 7;
            pre_mem[a][b2] = ~pre_mem[a][b2];
        end
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!dut_busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_timeout", ok, 1);
    endtask

    // Enable scrubbing for exactly one pass with random user-port contention
    task automatic run_pass(input int busy_pct);
        logic seen;
        seen = 1'b0;
        en   = 1'b1;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (pass_done) begin
                seen = 1'b1;
                en   = 1'b0;
                busy = 1'b0;
            end else begin
                busy = ($urandom_range(0, 99) < busy_pct);
            end
        end
        chk("pass_timeout", seen, 1);
        wait_idle();
    endtask

    task automatic compare_pass(input string tag);
        int n;
        chk({tag, "_nacc"}, log_q.size(), exp_q.size());
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_acc%0d", tag, i), log_q[i], exp_q[i]);
        for (int a = 0; a < DEPTH; a++)
            chk($sformatf("%s_mem%0d", tag, a), mem[a], exp_mem[a]);
        chk({tag, "_sbit"}, sbit_cnt, exp_s);
        chk({tag, "_dbit"}, dbit_cnt, exp_d);
        chk({tag, "_pdone"}, pd_cnt, 1);
        chk({tag, "_req_busy"}, busy_viol, 0);
`ifdef ECC_SCRUB_LOG_EN
        chk({tag, "_dflag"}, dbit_flag, exp_flag);
        if (exp_flag) chk({tag, "_daddr"}, dbit_addr, exp_daddr);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nreq, nwr, rd_t, wr_t;
        logic found, wb_ok;

        do_reset();
        chk("rst_busy", dut_busy, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_sbit", sbit_cnt, 0);
        chk("rst_dbit", dbit_cnt, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_pdone", pass_done, 0);

        // Clean bank: reads only, fixed word period
        fill_clean(); load_mem(); model_pass();
        run_pass(0);
        compare_pass("clean");
        chk("clean_gap", (stamp_q.size() > 1) ? stamp_q[1] - stamp_q[0] : 0, INTERVAL + 3);

        // Single-bit error at address 5, bit 2
        do_reset(); fill_clean();
        pre_mem[5][2] = ~pre_mem[5][2];
        load_mem(); model_pass();
        run_pass(0);
        compare_pass("sbit");
        chk("sbit_cnt1", sbit_cnt, 1);
        wb_ok = 1'b0; rd_t = -100; wr_t = 0;
        for (int i = 0; i < log_q.size(); i++) begin
            if (log_q[i] == {1'b1, 4'd5, orig[5]}) begin
                wb_ok = 1'b1;
                wr_t  = stamp_q[i];
            end
            if (log_q[i] == {1'b0, 4'd5, 7'd0}) rd_t = stamp_q[i];
        end
        chk("sbit_wb_orig", wb_ok, 1);
        chk("sbit_wb_lat", wr_t - rd_t, 2);

        // Double-bit error at address 9, bits 1 and 3
        do_reset(); fill_clean();
        pre_mem[9][1] = ~pre_mem[9][1];
        pre_mem[9][3] = ~pre_mem[9][3];
        load_mem(); model_pass();
        run_pass(0);
        compare_pass("dbit");
        chk("dbit_cnt1", dbit_cnt, 1);
`ifdef ECC_SCRUB_LOG_EN
        chk("dbit_log_addr", dbit_addr, 9);
        chk("dbit_log_flag", dbit_flag, 1);
`endif

        // User path busy across the whole first READ
        do_reset(); fill_clean(); load_mem();
        busy = 1'b1; en = 1'b1; nreq = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (mem_req) nreq++;
        end
        chk("busy_req_low", nreq, 0);
        chk("busy_active", dut_busy, 1);
        busy = 1'b0;
        #1;
        chk("busy_release_req", mem_req, 1);
        chk("busy_release_we", mem_we, 0);
        chk("busy_release_addr", mem_addr, 0);
        en = 1'b0;
        wait_idle();
        chk("busy_one_read", log_q.size(), 1);

        // Reset while a write-back is stalled by the user path
        do_reset(); fill_clean();
        pre_mem[3][0] = ~pre_mem[3][0];
        load_mem();
        en = 1'b1; found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_req && !mem_we && mem_addr == 4'd3) begin
                found = 1'b1;
                break;
            end
        end
        chk("wrst_read_seen", found, 1);
        @(negedge clk);
        busy = 1'b1;
        @(negedge clk);
        chk("wrst_pre_sbit", sbit_cnt, 1);
        rst = 1'b1; en = 1'b0;
        @(negedge clk);
        chk("wrst_busy", dut_busy, 0);
        chk("wrst_req", mem_req, 0);
        chk("wrst_sbit", sbit_cnt, 0);
        chk("wrst_dbit", dbit_cnt, 0);
        chk("wrst_addr", mem_addr, 0);
        rst = 1'b0; busy = 1'b0;
        repeat (10) @(negedge clk);
        chk("wrst_dropped", mem[3], pre_mem[3]);
        nwr = 0;
        for (int i = 0; i < log_q.size(); i++) if (log_q[i][11]) nwr++;
        chk("wrst_no_write", nwr, 0);

        // Five single-bit errors saturate a 2-bit counter; all rewritten
        do_reset(); fill_clean();
        for (int k = 0; k < 5; k++) flip(1 + 3 * k, 1);
        load_mem(); model_pass();
        run_pass(30);
        compare_pass("sat");
        chk("sat_cnt", sbit_cnt, 3);

        // Random corruption with random contention
        for (int r = 0; r < 3; r++) begin
            do_reset(); fill_clean();
            for (int a = 0; a < DEPTH; a++) begin
                int roll;
                roll = $urandom_range(0, 9);
                if (roll >= 9)      flip(a, 2);
                else if (roll >= 6) flip(a, 1);
            end
            load_mem(); model_pass();
            run_pass(40);
            compare_pass($sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
